// File: rtl/sync_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency dual-port RAM, presenting a
// first-word-fall-through output through a two-entry head/skid buffer.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam logic [ADDR_WIDTH:0] RAM_DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt;
    logic                  rd_pend_q, head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic                  full, ram_empty, push, pop;
    logic [1:0]            occ, occ_after;

    // Handshakes: a word moves on an edge only when valid and ready are both
    // high in the cycle before it; ready never depends on valid of the same port.
    assign ram_cnt   = wptr_q - rptr_q;
    assign full      = (ram_cnt == RAM_DEPTH_P);
    assign ram_empty = (wptr_q == rptr_q);

    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign mem_wr_en = push;
    assign mem_waddr = wptr_q[ADDR_WIDTH-1:0];
    assign mem_wdata = in_data;

    assign out_valid = head_v_q;
    assign out_data  = head_q;
    assign pop       = head_v_q && out_ready;

    // occ never exceeds 2: a fetch is only issued when a slot will be free.
    assign occ       = {1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};
    assign occ_after = occ - {1'b0, pop};
    assign mem_rd_en = !ram_empty && (occ_after < 2'd2);
    assign mem_raddr = rptr_q[ADDR_WIDTH-1:0];

    assign count = {1'b0, ram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_q}
                 + {{(ADDR_WIDTH+1){1'b0}}, head_v_q}
                 + {{(ADDR_WIDTH+1){1'b0}}, skid_v_q};

    assign wptr_d = push      ? wptr_q + PTR_ONE : wptr_q;
    assign rptr_d = mem_rd_en ? rptr_q + PTR_ONE : rptr_q;

    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (pop) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                head_v_d = 1'b0;
            end
        end
        // Returning RAM data lands behind whatever is still buffered.
        if (rd_pend_q) begin
            if (!head_v_q || (pop && !skid_v_q)) begin
                head_d   = mem_rdata;
                head_v_d = 1'b1;
            end else begin
                skid_d   = mem_rdata;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
            head_v_q  <= 1'b0;
            skid_v_q  <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_pend_q <= mem_rd_en;
            head_v_q  <= head_v_d;
            skid_v_q  <= skid_v_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl with a behavioural RAM and a queue-based
// scoreboard of every word held by the FIFO.
module tb_sync_fifo_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int CAP = (1 << AW) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_en;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ram [1 << AW];
    int            buffered = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_waddr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_raddr];
    end

    // Scoreboard: sampled mid-cycle, before this cycle's transfers apply.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            buffered  = 0;
            prev_hold = 1'b0;
        end else begin
            checks++;
            if (int'(count) != exp_q.size()) begin
                errors++;
                $display("FAIL count_model got %0d exp %0d", count, exp_q.size());
            end
            checks++;
            if (mem_wr_en !== (in_valid && in_ready)) begin
                errors++;
                $display("FAIL wr_en got %b exp %b", mem_wr_en, in_valid && in_ready);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra got %h exp none", out_data);
                end else if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_order got %h exp %h", out_data, exp_q[0]);
                end
            end
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable got %b/%h exp 1/%h", out_valid, out_data, prev_data);
                end
            end
            if (mem_rd_en === 1'b1) begin
                checks++;
                if (buffered - int'(out_valid && out_ready) >= 2) begin
                    errors++;
                    $display("FAIL fetch_limit got occ %0d exp <2", buffered - int'(out_valid && out_ready));
                end
            end
            if (mem_wr_en === 1'b1 && mem_rd_en === 1'b1) begin
                checks++;
                if (mem_waddr == mem_raddr) begin
                    errors++;
                    $display("FAIL collision got addr %0d exp distinct", mem_waddr);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            buffered  = buffered + int'(mem_rd_en) - int'(out_valid && out_ready);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (count != 0 && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (count != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d exp 0", count);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%h/%0d exp 0/00/0", out_valid, out_data, count);
        end
        checks++;
        if (in_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b exp 000", in_ready, mem_wr_en, mem_rd_en);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got %b exp 1", in_ready);
        end
    endtask

    task automatic test_latency;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_k got %b exp 0", out_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 1) begin
            errors++;
            $display("FAIL lat_k1 got %b/%0d exp 0/1", out_valid, count);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 1) begin
            errors++;
            $display("FAIL lat_k2 got %b/%h/%0d exp 1/a5/1", out_valid, out_data, count);
        end
        drain();
    endtask

    task automatic test_streaming;
        int sent, got, bubbles, max_cnt;
        logic seen;
        sent = 0; got = 0; bubbles = 0; max_cnt = 0; seen = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            in_valid = (sent < 100);
            in_data  = DW'(sent);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid) begin
                checks++;
                if (out_data !== DW'(got)) begin
                    errors++;
                    $display("FAIL stream_seq got %h exp %h", out_data, DW'(got));
                end
                seen = 1'b1;
                got++;
            end else if (seen) begin
                bubbles++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 100 || bubbles != 0 || max_cnt > 3) begin
            errors++;
            $display("FAIL stream_rate got %0d/%0d/%0d exp 100/0/<=3", got, bubbles, max_cnt);
        end
        drain();
    endtask

    task automatic test_full_wrap;
        int accepted;
        for (int lap = 0; lap < 3; lap++) begin
            tick();
            out_ready = 1'b0;
            accepted  = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
                @(negedge clk);
                if (in_ready) accepted++;
                tick();
            end
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (accepted != CAP || in_ready !== 1'b0 || count !== CAP) begin
                errors++;
                $display("FAIL full_cap got %0d/%b/%0d exp %0d/0/%0d", accepted, in_ready, count, CAP, CAP);
            end
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_not_comb got %b exp 0", in_ready);
            end
            tick();
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || count !== CAP - 1) begin
                errors++;
                $display("FAIL full_free got %b/%0d exp 1/%0d", in_ready, count, CAP - 1);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (count !== 5) begin
            errors++;
            $display("FAIL mid_fill got %0d exp 5", count);
        end
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || count !== 0 || in_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst got %b/%0d/%b/%b exp 0/0/0/0", out_valid, count, in_ready, mem_wr_en);
            end
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || count !== 0) begin
            errors++;
            $display("FAIL mid_release got %b/%0d exp 1/0", in_ready, count);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale got %b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        int sent, popped, cyc;
        sent = 0; popped = 0; cyc = 0;
        tick();
        while (popped < 2000 && cyc < 20000) begin
            in_valid  = (sent < 2000) && ($urandom_range(0, 1) == 1);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) popped++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (popped != 2000) begin
            errors++;
            $display("FAIL bp_timeout got %0d exp 2000", popped);
        end
        drain();
    endtask

    task automatic test_back_to_back;
        int n;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        in_data = DW'($urandom);
        @(negedge clk);
        while (in_ready && n < 30) begin
            tick();
            in_data = DW'($urandom);
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fill got %b exp 0", in_ready);
        end
        tick();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_data = DW'($urandom);
            @(negedge clk);
            if (cyc >= 4) begin
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rate got %b%b exp 11 at %0d", in_ready, out_valid, cyc);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_full_wrap();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got timeout exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO controller that sits in front of and behind the dual-port `memory` RAM with both RAM clocks tied to `clk`. It accepts a valid/ready input stream and generates the RAM write port (`wr_en`/`waddr`/`wdata`). It also drives the RAM read port (`rd_en`/`raddr`) and turns the RAM's registered, 1-cycle-latency `rdata` into a first-word-fall-through valid/ready output stream through a 2-entry output buffer. Total capacity is RAM_DEPTH + 2 words.

## Interface
- DATA_WIDTH, 8, data word width; must match RAM.
- ADDR_WIDTH, 8, RAM address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- clk  in  1  single clock; also drives the RAM `wr_clk` and `rd_clk`.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  controller accepts the word this cycle.
- in_data  in  DATA_WIDTH  input word.
- mem_wr_en  out  1  to RAM `wr_en`.
- mem_waddr  out  ADDR_WIDTH  to RAM `waddr`.
- mem_wdata  out  DATA_WIDTH  to RAM `wdata`.
- mem_rd_en  out  1  to RAM `rd_en`.
- mem_raddr  out  ADDR_WIDTH  to RAM `raddr`.
- mem_rdata  in  DATA_WIDTH  from RAM `rdata`; valid the cycle after `mem_rd_en`.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer takes the head word.
- out_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+2  total words held (RAM + in flight + output buffer).

## Operation
- Pointers:
  - `wptr`, `rptr` are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - `ram_cnt = wptr - rptr`, modulo 2^(ADDR_WIDTH+1).
  - `full = (ram_cnt == RAM_DEPTH)`; `ram_empty = (wptr == rptr)`.
- Write:
  - `in_ready = !full && !rst`.
  - `push = in_valid && in_ready`.
  - `mem_wr_en = push`, `mem_waddr = wptr[ADDR_WIDTH-1:0]`, `mem_wdata = in_data`; all combinational.
  - `wptr` increments on push.
- Output buffer:
  - Holds `head` (drives `out_valid`/`out_data`) and `skid`.
  - `rd_pend` is a flag register equal to `mem_rd_en` delayed one cycle.
  - `pop = out_valid && out_ready`.
  - `occ = head_v + skid_v + rd_pend`, range 0..2.
- Fetch:
  - `mem_rd_en = !ram_empty && (occ - pop) < 2`.
  - `mem_raddr = rptr[ADDR_WIDTH-1:0]`.
  - `rptr` increments on `mem_rd_en`.
- Capture: when `rd_pend` is set, `mem_rdata` is loaded at the next edge:
  - into `head` if the head is empty or being popped while the skid is empty;
  - otherwise into `skid`.
- On pop with `skid_v` set, skid moves to head. Words leave in strict arrival order.
- `count = ram_cnt + rd_pend + head_v + skid_v`. Maximum is RAM_DEPTH + 2, which fits in ADDR_WIDTH+2 bits.
- Collision-free by construction: a read uses the registered `rptr`, which is strictly behind the registered `wptr`. The address being read was therefore written at least one edge earlier, so no same-address read/write occurs in one cycle.

## Timing
- Reset (async, active-high): clears `wptr`, `rptr`, `rd_pend`, `head_v`, `skid_v`, `head`, `skid`. Effects:
  - `out_valid=0`, `out_data=0`, `count=0`.
  - `mem_wr_en=0`, `mem_rd_en=0`, `in_ready=0` while `rst` is high.
  - `in_ready=1` in the first cycle after release.
- Reset mid-operation: all contents are discarded immediately. RAM contents are left stale and are never read.
- Fall-through latency, empty FIFO: a word pushed at edge k gives `out_valid=1` after edge k+2. Sequence: `mem_rd_en` in cycle k→k+1, `rd_pend` in cycle k+1→k+2.
- Throughput: with `out_ready` held high and a continuous input, one word per cycle out after the initial 2-cycle fill.
- `out_valid && !out_ready`: `out_data` must be held stable.
- Full: `in_ready=0` when `ram_cnt==RAM_DEPTH`. A pop that frees RAM space (through `mem_rd_en`) raises `in_ready` on the following cycle, not combinationally.
- Simultaneous push and fetch in the same cycle is permitted. With a full RAM, the fetch frees the slot and `in_ready` rises the next cycle.
- Pointer wrap: the address wraps RAM_DEPTH-1 → 0; the wrap bit toggles. Full and empty stay distinct.

## Test plan
- Reset/idle: assert `rst` mid-run with 5 words held → `out_valid=0`, `count=0`, `in_ready=0` while asserted; `in_ready=1` the cycle after release.
- Latency: empty, DATA_WIDTH=8, push 0xA5 at edge k → `out_valid=1`, `out_data=0xA5` after edge k+2; `count` reads 1 from edge k+1.
- Streaming: push 0..99 back-to-back, `out_ready=1` → outputs 0..99 in order at one per cycle from first valid, `count` ≤ 3, no bubbles after fill.
- Full/wrap (ADDR_WIDTH=3): push with `out_ready=0` → exactly 10 words accepted, then `in_ready=0`, `count=10`. Then pop 1 → `in_ready=1` one cycle later. Repeat 3 laps → data in order across wrap.
- Backpressure: random `out_ready` (50%) and random `in_valid` over 2000 words → scoreboard match. `out_data` is stable whenever `out_valid && !out_ready`. `mem_rd_en` never fires with `occ - pop` = 2.
- Concurrency: full RAM, `out_ready=1`, `in_valid=1` continuously → one push and one pop per cycle in steady state. No `mem_waddr == mem_raddr` with both enables set.
